// File: rtl/rom_fetch_queue_if.sv
// Fetch-queue bus: ROM read port 1 plus redirect and decoder valid/ready handshake.
interface rom_fetch_queue_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;

  // Fetch side: drives the ROM address and the instruction stream.
  modport master (
    output rom_addr, out_valid, out_instr, out_pc,
    input  rom_data, redirect, redirect_pc, out_ready
  );

  // ROM/decoder/branch-unit side.
  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc,
    output rom_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/rom_fetch_queue.sv
// Instruction-fetch sequencer for ROM read port 1 with a small {pc,instr} FIFO toward decode.
// Optional FETCHQ_PERF_EN adds a saturating empty-queue stall counter on port stall_cnt.
module rom_fetch_queue #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCHQ_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  rom_fetch_queue_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [31:0]       fetch_pc, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]  count, count_d;
  logic              push_c, pop_c;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  // Next-state: redirect flushes and overrides any push/pop in the same cycle.
  always_comb begin
    fetch_pc_d = fetch_pc;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    count_d    = count;
    pop_c      = (count != '0) & bus.out_ready & ~bus.redirect;
    push_c     = ~bus.redirect & ((count != CNT_W'(DEPTH)) | pop_c);
    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (push_c) begin
        wr_ptr_d   = wr_ptr + PTR_W'(1);
        fetch_pc_d = fetch_pc + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr + PTR_W'(1);
      end
      count_d = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      fetch_pc <= fetch_pc_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      if (push_c) begin
        mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.rom_data};
      end
    end
  end

  // Outputs come straight from registered state; the ROM captures in the same cycle it is addressed.
  assign bus.rom_addr  = fetch_pc[ADDR_W+1:2];
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = mem[rd_ptr].instr;
  assign bus.out_pc    = mem[rd_ptr].pc;

`ifdef FETCHQ_PERF_EN
  // Counts cycles the decoder is starved, excluding redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!bus.redirect && (count == '0) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rom_fetch_queue.sv
// Randomized self-checking bench for rom_fetch_queue against a queue-based fetch model.
// Define FETCHQ_PERF_EN to also check stall_cnt.
module tb_rom_fetch_queue;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCHQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  rom_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FETCHQ_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_stall;
  bit          started = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a PC stream into a bounded queue, with flush on redirect or reset.
  task automatic model_step(input logic rn, input logic rd, input logic [31:0] rpc, input logic rdy);
    bit pop, push;
    if (!rn) begin
      mq.delete();
      m_pc    = 32'h0;
      m_stall = 32'h0;
    end else if (rd) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      pop  = (mq.size() != 0) && rdy;
      push = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: m_pc, instr: rom_word(m_pc[ADDR_W+1:2])});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input logic rn, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n           = rn;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    bus.rom_data    = rom_word(bus.rom_addr);
    @(posedge clk);
    model_step(rn, rd, rpc, rdy);
    if (!rn) started = 1'b1;
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_pc[ADDR_W+1:2]));
      if (mq.size() != 0) begin
        chk("out_pc", bus.out_pc, mq[0].pc);
        chk("out_instr", bus.out_instr, mq[0].instr);
      end
`ifdef FETCHQ_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0; bus.rom_data = '0;
    m_pc = '0; m_stall = '0;

    // Streaming after reset.
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    cyc(1, 0, 0, 1);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc0", bus.out_pc, 32'h0);
    chk("t1_instr0", bus.out_instr, 32'h1000_0000);
    repeat (3) cyc(1, 0, 0, 1);
    chk("t1_pc3", bus.out_pc, 32'hC);
    chk("t1_instr3", bus.out_instr, 32'h1000_0003);

    // Backpressure fills the queue and freezes the fetch address.
    cyc(0, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    chk("t2_rom_addr", 32'(bus.rom_addr), 32'd4);
    chk("t2_head_pc", bus.out_pc, 32'h0);
    repeat (8) cyc(1, 0, 0, 1);

    // Redirect while full; unaligned target.
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h0000_0103, 1);
    chk("t3_flush", 32'(bus.out_valid), 32'd0);
    cyc(1, 0, 0, 1);
    chk("t3_pc", bus.out_pc, 32'h100);
    chk("t3_instr", bus.out_instr, 32'h1000_0040);

    // ROM address wraps while the byte PC keeps counting.
    cyc(1, 1, 32'h0000_FFFC, 1);
    chk("t4_addr_hi", 32'(bus.rom_addr), 32'h3FFF);
    cyc(1, 0, 0, 1);
    chk("t4_addr_lo", 32'(bus.rom_addr), 32'h0);
    chk("t4_pc_a", bus.out_pc, 32'hFFFC);
    cyc(1, 0, 0, 1);
    chk("t4_pc_b", bus.out_pc, 32'h1_0000);

    // Reset with the queue partly filled.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rom_addr", 32'(bus.rom_addr), 32'd0);
    cyc(1, 0, 0, 1);
    chk("t5_pc", bus.out_pc, 32'h0);

`ifdef FETCHQ_PERF_EN
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("t6_stall_a", stall_cnt, 32'd1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h40, 1);
    chk("t6_stall_redir", stall_cnt, 32'd1);
    cyc(1, 0, 0, 1);
    chk("t6_stall_b", stall_cnt, 32'd2);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      cyc(r != 0, (r >= 1 && r <= 5), $urandom, $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
